ad9364_dac_pattern_gen: RTL and testbench

Parametrised DAC test-pattern source feeding the dac_valid/dac_data_* inputs of the AD9364 digital interface.
It replaces the fixed two-level square-wave generator and supports four modes: constant, programmable table sequence, ramp and two-level square.
It adds a programmable per-sample hold count and optional second-channel generation.
It runs entirely in the interface clock domain, so no divided clock derived from delay_clk is needed.

---
 rtl/ad9364_dac_pattern_gen_pkg.sv | 21 ++
 rtl/ad9364_pattern_table.sv | 39 +++
 rtl/ad9364_dac_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_ad9364_dac_pattern_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9364_dac_pattern_gen_pkg.sv
// Shared mode encodings and table-length helper for the AD9364 DAC pattern source.
package ad9364_dac_pattern_gen_pkg;

  localparam logic [1:0] MODE_CONST  = 2'd0;
  localparam logic [1:0] MODE_TABLE  = 2'd1;
  localparam logic [1:0] MODE_RAMP   = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  localparam int SQUARE_LEN = 2;

  // A zero length still plays entry 0; anything beyond the table is clamped to its depth.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
    if (len == 0)
      return 1;
    else if (len > depth)
      return depth;
    else
      return len;
  endfunction

endpackage

// File: rtl/ad9364_pattern_table.sv
// I/Q pattern register file: sync write, registered read with write-through, sync clear.
// One-cycle read latency on both ports; no backpressure.
module ad9364_pattern_table
  import ad9364_dac_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int PATTERN_DEPTH = 8,
  parameter int ADDR_WIDTH    = $clog2(PATTERN_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] i_wr_dat,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [2*DATA_WIDTH-1:0] o_rd_dat,
  output logic [2*DATA_WIDTH-1:0] o_ent0_dat
);

  logic [2*DATA_WIDTH-1:0] r_mem [PATTERN_DEPTH];

  // Write-through so a write is visible on the very next read, matching a one-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PATTERN_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      o_rd_dat   <= '0;
      o_ent0_dat <= '0;
    end else begin
      if (i_wr) begin
        r_mem[i_wr_addr] <= i_wr_dat;
      end
      o_rd_dat   <= (i_wr && (i_wr_addr == i_rd_addr)) ? i_wr_dat : r_mem[i_rd_addr];
      o_ent0_dat <= (i_wr && (i_wr_addr == '0)) ? i_wr_dat : r_mem[0];
    end
  end

endmodule

// File: rtl/ad9364_dac_pattern_gen.sv
// DAC test-pattern source (constant/table/ramp/square) for the AD9364 dig_if dac_* inputs.
// Outputs registered, 1 cycle from sampled inputs; no backpressure, dac_valid free-runs 1,0,1,0.
module ad9364_dac_pattern_gen
  import ad9364_dac_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int PATTERN_DEPTH = 8,
  parameter int HOLD_WIDTH    = 16,
  parameter int ADDR_WIDTH    = $clog2(PATTERN_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  r1_mode,
  input  logic [HOLD_WIDTH-1:0] hold_count,
  input  logic [ADDR_WIDTH:0]   pattern_len,
  input  logic                  tbl_wr,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data_i,
  input  logic [DATA_WIDTH-1:0] tbl_data_q,
  output logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_data_i1,
  output logic [DATA_WIDTH-1:0] dac_data_q1,
  output logic [DATA_WIDTH-1:0] dac_data_i2,
  output logic [DATA_WIDTH-1:0] dac_data_q2,
  output logic                  dac_r1_mode,
  output logic                  seq_wrap
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;

  logic            r_phase;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic [AW-1:0]   r_idx;
  logic [DW-1:0]   r_acc;
  logic            r_wrap_pend;
  logic [1:0]      r_mode;
  logic [LW-1:0]   r_len;

  logic            w_strobe;
  logic            w_restart;
  logic [AW-1:0]   w_idx_cur;
  logic [DW-1:0]   w_acc_cur;
  logic [HOLD_WIDTH-1:0] w_hold_cur;
  logic            w_pend_cur;
  logic            w_advance;
  logic            w_pos_zero;
  logic            w_wrap_pulse;
  logic [AW-1:0]   w_last;
  logic [AW-1:0]   w_idx_nxt;
  logic [DW-1:0]   w_acc_nxt;
  logic [HOLD_WIDTH-1:0] w_hold_nxt;
  logic            w_pend_nxt;
  logic [2*DW-1:0] w_rd_dat;
  logic [2*DW-1:0] w_ent0;
  logic [2*DW-1:0] w_tbl_dat;
  logic [DW-1:0]   w_smp_i;
  logic [DW-1:0]   w_smp_q;

  ad9364_pattern_table #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PATTERN_DEPTH (PATTERN_DEPTH),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (tbl_wr),
    .i_wr_addr  (tbl_addr),
    .i_wr_dat   ({tbl_data_i, tbl_data_q}),
    .i_rd_addr  (w_idx_nxt),
    .o_rd_dat   (w_rd_dat),
    .o_ent0_dat (w_ent0)
  );

  assign w_strobe  = enable & ~r_phase;
  assign w_restart = enable & ((mode != r_mode) | (pattern_len != r_len));

  // A restart behaves as if the sequence state were already back at its origin this cycle.
  assign w_idx_cur  = w_restart ? '0 : r_idx;
  assign w_acc_cur  = w_restart ? '0 : r_acc;
  assign w_hold_cur = w_restart ? '0 : r_hold;
  assign w_pend_cur = w_restart ? 1'b0 : r_wrap_pend;

  assign w_advance    = w_strobe & (w_hold_cur == hold_count);
  assign w_pos_zero   = (mode == MODE_RAMP) ? (w_acc_cur == '0) : (w_idx_cur == '0);
  assign w_wrap_pulse = w_strobe & (mode != MODE_CONST) & w_pos_zero & w_pend_cur;
  assign w_last       = (mode == MODE_SQUARE) ? AW'(SQUARE_LEN - 1)
                      : AW'(eff_len(32'(pattern_len), PATTERN_DEPTH) - 32'd1);

  always_comb begin
    w_idx_nxt  = w_idx_cur;
    w_acc_nxt  = w_acc_cur;
    w_hold_nxt = w_hold_cur;
    w_pend_nxt = w_pend_cur & ~w_wrap_pulse;
    if (!enable) begin
      w_idx_nxt  = '0;
      w_acc_nxt  = '0;
      w_hold_nxt = '0;
      w_pend_nxt = 1'b0;
    end else if (w_strobe) begin
      if (w_advance) begin
        w_hold_nxt = '0;
        case (mode)
          MODE_TABLE, MODE_SQUARE: begin
            if (w_idx_cur == w_last) begin
              w_idx_nxt  = '0;
              w_pend_nxt = 1'b1;
            end else begin
              w_idx_nxt = w_idx_cur + AW'(1);
            end
          end
          MODE_RAMP: begin
            w_acc_nxt = w_acc_cur + DW'(1);
            if (w_acc_cur == '1) begin
              w_pend_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        w_hold_nxt = w_hold_cur + HOLD_WIDTH'(1);
      end
    end
  end

  // The table read port already follows r_idx; entry 0 covers a restart landing on a strobe.
  assign w_tbl_dat = w_restart ? w_ent0 : w_rd_dat;

  always_comb begin
    w_smp_i = w_ent0[2*DW-1:DW];
    w_smp_q = w_ent0[DW-1:0];
    case (mode)
      MODE_TABLE, MODE_SQUARE: begin
        w_smp_i = w_tbl_dat[2*DW-1:DW];
        w_smp_q = w_tbl_dat[DW-1:0];
      end
      MODE_RAMP: begin
        w_smp_i = w_acc_cur;
        w_smp_q = ~w_acc_cur;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= 1'b0;
      r_hold      <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_wrap_pend <= 1'b0;
      r_mode      <= '0;
      r_len       <= '0;
      dac_valid   <= 1'b0;
      dac_data_i1 <= '0;
      dac_data_q1 <= '0;
      dac_data_i2 <= '0;
      dac_data_q2 <= '0;
      dac_r1_mode <= 1'b1;
      seq_wrap    <= 1'b0;
    end else begin
      r_phase     <= enable ? ~r_phase : 1'b0;
      r_hold      <= w_hold_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_wrap_pend <= w_pend_nxt;
      r_mode      <= mode;
      r_len       <= pattern_len;
      dac_valid   <= w_strobe;
      seq_wrap    <= w_wrap_pulse;
      dac_r1_mode <= r1_mode;
      if (w_strobe) begin
        dac_data_i1 <= w_smp_i;
        dac_data_q1 <= w_smp_q;
        dac_data_i2 <= r1_mode ? '0 : w_smp_q;
        dac_data_q2 <= r1_mode ? '0 : w_smp_i;
      end
    end
  end

endmodule

// File: tb/tb_ad9364_dac_pattern_gen.sv
// Bench for ad9364_dac_pattern_gen: directed scenarios plus random traffic against a
// strobe-count model (sample = strobes / (hold+1), position = sample mod length).
module tb_ad9364_dac_pattern_gen;
  import ad9364_dac_pattern_gen_pkg::*;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int HW    = 16;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic          r1_mode;
  logic [HW-1:0] hold_count;
  logic [AW:0]   pattern_len;
  logic          tbl_wr;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data_i;
  logic [DW-1:0] tbl_data_q;
  logic          dac_valid;
  logic [DW-1:0] dac_data_i1;
  logic [DW-1:0] dac_data_q1;
  logic [DW-1:0] dac_data_i2;
  logic [DW-1:0] dac_data_q2;
  logic          dac_r1_mode;
  logic          seq_wrap;

  always #5 clk = ~clk;

  ad9364_dac_pattern_gen #(
    .DATA_WIDTH    (DW),
    .PATTERN_DEPTH (DEPTH),
    .HOLD_WIDTH    (HW),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .r1_mode     (r1_mode),
    .hold_count  (hold_count),
    .pattern_len (pattern_len),
    .tbl_wr      (tbl_wr),
    .tbl_addr    (tbl_addr),
    .tbl_data_i  (tbl_data_i),
    .tbl_data_q  (tbl_data_q),
    .dac_valid   (dac_valid),
    .dac_data_i1 (dac_data_i1),
    .dac_data_q1 (dac_data_q1),
    .dac_data_i2 (dac_data_i2),
    .dac_data_q2 (dac_data_q2),
    .dac_r1_mode (dac_r1_mode),
    .seq_wrap    (seq_wrap)
  );

  logic [2*DW-1:0] m_mem [DEPTH];
  int              m_n;
  bit              m_phase;
  logic [1:0]      m_pm;
  logic [AW:0]     m_pl;
  logic            e_valid, e_r1, e_wrap;
  logic [DW-1:0]   e_i1, e_q1, e_i2, e_q2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Predicts the outputs produced by the coming rising edge from the inputs now driven.
  task automatic model_edge();
    int hp1, s, r, l, idx;
    logic [2*DW-1:0] ent;
    logic [DW-1:0]   si, sq;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      m_n = 0; m_phase = 0; m_pm = '0; m_pl = '0;
      e_valid = 0; e_wrap = 0; e_r1 = 1;
      e_i1 = '0; e_q1 = '0; e_i2 = '0; e_q2 = '0;
    end else begin
      e_r1 = r1_mode; e_valid = 0; e_wrap = 0;
      if (!enable) begin
        m_phase = 0; m_n = 0;
      end else begin
        if (mode != m_pm || pattern_len != m_pl) m_n = 0;
        if (!m_phase) begin
          hp1 = int'(hold_count) + 1;
          s = m_n / hp1;
          r = m_n % hp1;
          l = (pattern_len == 0) ? 1 : ((int'(pattern_len) > DEPTH) ? DEPTH : int'(pattern_len));
          ent = m_mem[0];
          si = ent[2*DW-1:DW];
          sq = ent[DW-1:0];
          case (mode)
            MODE_TABLE: begin
              idx = s % l; ent = m_mem[idx];
              si = ent[2*DW-1:DW]; sq = ent[DW-1:0];
              e_wrap = (idx == 0) && (s > 0) && (r == 0);
            end
            MODE_SQUARE: begin
              idx = s % 2; ent = m_mem[idx];
              si = ent[2*DW-1:DW]; sq = ent[DW-1:0];
              e_wrap = (idx == 0) && (s > 0) && (r == 0);
            end
            MODE_RAMP: begin
              si = DW'(s % (1 << DW)); sq = ~si;
              e_wrap = (s % (1 << DW) == 0) && (s > 0) && (r == 0);
            end
            default: ;
          endcase
          e_valid = 1;
          e_i1 = si; e_q1 = sq;
          e_i2 = r1_mode ? '0 : sq;
          e_q2 = r1_mode ? '0 : si;
          m_n++;
        end
        m_phase = !m_phase;
      end
      m_pm = mode; m_pl = pattern_len;
      if (tbl_wr) m_mem[tbl_addr] = {tbl_data_i, tbl_data_q};
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("dac_valid",   32'(dac_valid),   32'(e_valid));
      chk("dac_data_i1", 32'(dac_data_i1), 32'(e_i1));
      chk("dac_data_q1", 32'(dac_data_q1), 32'(e_q1));
      chk("dac_data_i2", 32'(dac_data_i2), 32'(e_i2));
      chk("dac_data_q2", 32'(dac_data_q2), 32'(e_q2));
      chk("dac_r1_mode", 32'(dac_r1_mode), 32'(e_r1));
      chk("seq_wrap",    32'(seq_wrap),    32'(e_wrap));
    end
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] di, input logic [DW-1:0] dq);
    tbl_wr = 1; tbl_addr = AW'(addr); tbl_data_i = di; tbl_data_q = dq;
    step(1);
    tbl_wr = 0;
  endtask

  initial begin
    rst = 1; enable = 0; mode = MODE_CONST; r1_mode = 1; hold_count = '0;
    pattern_len = '0; tbl_wr = 0; tbl_addr = '0; tbl_data_i = '0; tbl_data_q = '0;
    step(2);
    rst = 0;
    step(1);

    // Square wave, hold 0
    wr(0, 12'h7FF, 12'h7FF);
    wr(1, 12'h800, 12'h7FF);
    mode = MODE_SQUARE; enable = 1;
    step(12);
    enable = 0; step(2);

    // Table 1..5, hold 2
    for (int k = 0; k < 5; k++) wr(k, DW'(k + 1), DW'($urandom_range(0, 4095)));
    mode = MODE_TABLE; pattern_len = 4'd5; hold_count = 16'd2; enable = 1;
    step(40);
    enable = 0; step(2);

    // Ramp through the 12-bit wrap
    mode = MODE_RAMP; hold_count = '0; enable = 1;
    step(8200);
    enable = 0; step(2);

    // Channel 2 swap then single channel
    wr(0, 12'h123, 12'h456);
    mode = MODE_TABLE; pattern_len = 4'd1; r1_mode = 0; enable = 1;
    step(6);
    r1_mode = 1;
    step(6);
    enable = 0; step(2);

    // Length 0 and clamped length 9
    pattern_len = 4'd0; enable = 1; step(10);
    enable = 0; step(1);
    for (int k = 0; k < DEPTH; k++) wr(k, DW'($urandom), DW'($urandom));
    pattern_len = 4'd9; enable = 1; step(40);

    // Enable drop mid-hold, then re-enable
    enable = 0; hold_count = 16'd1; step(1);
    enable = 1; step(5);
    enable = 0; step(3);
    enable = 1; step(10);

    // Reset while running, then read entry 0 back in constant mode
    rst = 1; step(1);
    rst = 0; mode = MODE_CONST; hold_count = '0; step(6);
    enable = 0; step(1);

    // Table -> ramp switch mid-sequence
    for (int k = 0; k < 6; k++) wr(k, DW'($urandom), DW'($urandom));
    mode = MODE_TABLE; pattern_len = 4'd6; hold_count = 16'd1; enable = 1;
    step(7);
    mode = MODE_RAMP; step(6);

    // Write to the presented entry on its strobe
    mode = MODE_CONST; hold_count = '0; step(3);
    if (m_phase) step(1);
    wr(0, 12'hABC, 12'h321);
    step(4);
    mode = MODE_TABLE; pattern_len = 4'd3; hold_count = 16'd1; step(2);
    if (m_phase) step(1);
    wr(0, 12'h5A5, 12'hA5A);
    step(12);

    // Random traffic
    for (int seg = 0; seg < 200; seg++) begin
      enable = ($urandom_range(0, 4) != 0);
      if (!enable) hold_count = HW'($urandom_range(0, 3));
      if (!enable || $urandom_range(0, 3) == 0) begin
        mode = 2'($urandom_range(0, 3));
        pattern_len = 4'($urandom_range(0, 15));
        r1_mode = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < int'($urandom_range(1, 20)); c++) begin
        tbl_wr = ($urandom_range(0, 3) == 0);
        tbl_addr = AW'($urandom_range(0, DEPTH - 1));
        tbl_data_i = DW'($urandom);
        tbl_data_q = DW'($urandom);
        step(1);
      end
      tbl_wr = 0;
    end
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
